cnt5_arb: RTL

Round-robin arbiter sharing one modulo-5 event counter among four requesters. Each granted request advances the counter by exactly one. A four-phase req/gnt handshake ensures each request is counted only once. The block wraps the 3-bit mod-5 counter and replaces the single `inc` input with a multi-client front end, so several producers can share one counter.

---
 rtl/cnt5_arb.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cnt5_arb.sv
// -----------------------------------------------------------------------------
// cnt5_arb
//
// Round-robin arbiter in front of a shared modulo-(CNT_MAX+1) event counter.
// Up to NREQ producers raise a request level; one winner at a time receives a
// single-cycle grant pulse, the counter advances by exactly one for that
// grant, and the arbiter then waits for the winner to drop its request before
// arbitrating again. A request still high after its grant is never counted
// twice.
//
// Optional feature macro: CNT5_ARB_CLR_EN
//   When defined, the `clr` input exists and synchronously forces the counter
//   (and wrap) to zero without disturbing the grant sequence.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   CNT_MAX  terminal count, counter runs 0..CNT_MAX (1..7)
//
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   req      per-requester request level
//   clr      synchronous counter clear (only with CNT5_ARB_CLR_EN)
//   gnt      registered one-hot grant, one cycle wide
//   cnt      registered counter value
//   wrap     registered one-cycle pulse when cnt returns from CNT_MAX to 0
//   busy     registered, high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module cnt5_arb #(
  parameter int NREQ    = 4,
  parameter int CNT_MAX = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
`ifdef CNT5_ARB_CLR_EN
  input  logic            clr,
`endif
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      cnt,
  output logic            wrap,
  output logic            busy
);

  localparam int PTR_W = $clog2(NREQ);

  localparam logic [2:0]       CNT_MAX_C  = 3'(CNT_MAX);
  localparam logic [PTR_W:0]   NREQ_C     = (PTR_W+1)'(NREQ);
  localparam logic [PTR_W-1:0] LAST_IDX_C = PTR_W'(NREQ-1);
  localparam logic [PTR_W-1:0] ZERO_IDX_C = {PTR_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t            state_r;
  logic [PTR_W-1:0]  ptr_r;
  logic [PTR_W-1:0]  win_r;
  logic [NREQ-1:0]   gnt_r;
  logic [2:0]        cnt_r;
  logic              wrap_r;
  logic              busy_r;

  logic              any_req_s;
  logic [PTR_W-1:0]  win_idx_s;
  logic [PTR_W:0]    raw_idx_s;
  logic [PTR_W:0]    scan_idx_s;

  // Next counter value; the >= compare keeps an out-of-range value from
  // ever propagating, it simply folds back to zero.
  function automatic logic [2:0] cnt_next(input logic [2:0] c);
    if (c >= CNT_MAX_C) begin
      return 3'd0;
    end else begin
      return c + 3'd1;
    end
  endfunction

  // Requester index plus one, wrapping at NREQ (NREQ need not be a power of two).
  function automatic logic [PTR_W-1:0] idx_inc(input logic [PTR_W-1:0] i);
    if (i >= LAST_IDX_C) begin
      return ZERO_IDX_C;
    end else begin
      return i + PTR_W'(1'b1);
    end
  endfunction

  // Index to one-hot grant vector.
  function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] i);
    logic [NREQ-1:0] v;
    v    = {NREQ{1'b0}};
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin search starting at ptr_r. The loop walks offsets from the
  // farthest to the nearest so the last hit (smallest offset) wins.
  always_comb begin
    any_req_s  = 1'b0;
    win_idx_s  = ZERO_IDX_C;
    raw_idx_s  = {(PTR_W+1){1'b0}};
    scan_idx_s = {(PTR_W+1){1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      raw_idx_s  = {1'b0, ptr_r} + (PTR_W+1)'(k);
      scan_idx_s = (raw_idx_s >= NREQ_C) ? (raw_idx_s - NREQ_C) : raw_idx_s;
      any_req_s  = any_req_s | req[scan_idx_s[PTR_W-1:0]];
      win_idx_s  = req[scan_idx_s[PTR_W-1:0]] ? scan_idx_s[PTR_W-1:0] : win_idx_s;
    end
  end

  // Arbitration FSM with the counter; every output is a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= ZERO_IDX_C;
      win_r   <= ZERO_IDX_C;
      gnt_r   <= {NREQ{1'b0}};
      cnt_r   <= 3'd0;
      wrap_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      // wrap is a pulse: cleared unless the GRANT branch sets it this cycle
      wrap_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            gnt_r   <= onehot(win_idx_s);
            win_r   <= win_idx_s;
            busy_r  <= 1'b1;
            state_r <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          gnt_r   <= {NREQ{1'b0}};
          cnt_r   <= cnt_next(cnt_r);
          wrap_r  <= (cnt_r >= CNT_MAX_C);
          ptr_r   <= idx_inc(win_r);
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // Only the winner's own release ends the transaction; others queue
          // up and are arbitrated once back in IDLE.
          if (!req[win_r]) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          gnt_r   <= {NREQ{1'b0}};
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
`ifdef CNT5_ARB_CLR_EN
      // Clear wins over a coincident increment but leaves the FSM alone.
      if (clr) begin
        cnt_r  <= 3'd0;
        wrap_r <= 1'b0;
      end
`endif
    end
  end

  assign gnt  = gnt_r;
  assign cnt  = cnt_r;
  assign wrap = wrap_r;
  assign busy = busy_r;

endmodule
